// File: rtl/line_buffer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer_ctrl_if
//  Description : Pixel-input / line-buffer / window bundle for
//                line_buffer_ctrl. The slave modport is the controller; the
//                master modport is the surrounding datapath / line buffers.
//  Revision    : 1.0  initial release
// ============================================================================
interface line_buffer_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                        inPixelValid;
    logic [4*3*DATA_WIDTH-1:0]   lbRdData;
    logic [3:0]                  lbWrEn;
    logic [3:0]                  lbRdEn;
    logic [9*DATA_WIDTH-1:0]     window;
    logic                        windowValid;
    logic                        rdBuffEmpty;
    logic                        ovfErr;

    modport master (
        output inPixelValid,
        output lbRdData,
        input  lbWrEn,
        input  lbRdEn,
        input  window,
        input  windowValid,
        input  rdBuffEmpty,
        input  ovfErr
    );

    modport slave (
        input  inPixelValid,
        input  lbRdData,
        output lbWrEn,
        output lbRdEn,
        output window,
        output windowValid,
        output rdBuffEmpty,
        output ovfErr
    );
endinterface
`default_nettype wire

// File: rtl/line_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer_ctrl
//  Description : Sequences four line buffers feeding a 3x3 kernel. Writes
//                fill the buffers round-robin; once three lines are stored
//                a READ burst of IMG_WIDTH cycles assembles 3x3 windows from
//                the three oldest lines.
//  Options     : LB_CTRL_OVF_DET_EN - enables the sticky ovfErr flag set on
//                any dropped write (otherwise ovfErr is tied low).
//  Revision    : 1.0  initial release
// ============================================================================
module line_buffer_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 512
) (
    input  wire logic           clk,
    input  wire logic           rst,
    line_buffer_ctrl_if.slave   bus
);

    localparam int PIX_W  = $clog2(IMG_WIDTH);
    localparam int FILL_W = $clog2(4*IMG_WIDTH + 1);
    localparam int ROW_W  = 3*DATA_WIDTH;

    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(4*IMG_WIDTH);
    localparam logic [FILL_W-1:0] FILL_READY = FILL_W'(3*IMG_WIDTH);
    localparam logic [PIX_W-1:0]  PIX_LAST   = PIX_W'(IMG_WIDTH-1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [1:0]         wr_line_sel;
    logic [PIX_W-1:0]   wr_pix_cnt;
    logic [1:0]         rd_line_sel;
    logic [1:0]         rd_sel1;
    logic [1:0]         rd_sel2;
    logic [PIX_W-1:0]   rd_pix_cnt;
    logic [FILL_W-1:0]  fill_cnt;
    logic               rd_buff_empty;

    logic               reading;
    logic               rd_last;
    logic               wr_drop;
    logic               wr_accept;
    logic               read_start;

    logic [ROW_W-1:0]   taps [4];

    assign reading    = (state == ST_READ);
    assign rd_last    = reading && (rd_pix_cnt == PIX_LAST);
    // A write is only lost when every buffer slot is occupied and no read
    // frees one in the same cycle.
    assign wr_drop    = bus.inPixelValid && (fill_cnt == FILL_FULL) && !reading;
    assign wr_accept  = bus.inPixelValid && !wr_drop;
    assign read_start = (state == ST_IDLE) && (state_next == ST_READ);
    assign rd_sel1    = rd_line_sel + 2'd1;
    assign rd_sel2    = rd_line_sel + 2'd2;

    // Split the packed tap bus into one row per line buffer.
    for (genvar n = 0; n < 4; n++) begin : g_tap
        assign taps[n] = bus.lbRdData[n*ROW_W +: ROW_W];
    end

    // Window rows: oldest line (rd_line_sel) in the low bits.
    always_comb begin
        bus.window = {taps[rd_sel2], taps[rd_sel1], taps[rd_line_sel]};
    end

    // One-hot write steering to the buffer currently being filled.
    always_comb begin
        bus.lbWrEn = 4'b0000;
        if (wr_accept) begin
            bus.lbWrEn = 4'b0001 << wr_line_sel;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read FSM next-state and read-side outputs.
    always_comb begin
        state_next      = state;
        bus.lbRdEn      = 4'b0000;
        bus.windowValid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fill_cnt >= FILL_READY) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                bus.lbRdEn      = (4'b0001 << rd_line_sel) |
                                  (4'b0001 << rd_sel1)     |
                                  (4'b0001 << rd_sel2);
                bus.windowValid = 1'b1;
                if (rd_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Write pointer: pixel count within the line, then next buffer on wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_pix_cnt  <= '0;
            wr_line_sel <= 2'd0;
        end else if (wr_accept) begin
            wr_pix_cnt <= wr_pix_cnt + 1'b1;
            if (wr_pix_cnt == PIX_LAST) begin
                wr_line_sel <= wr_line_sel + 2'd1;
            end
        end
    end

    // Read pointer: advances every READ cycle, oldest line moves on at the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pix_cnt  <= '0;
            rd_line_sel <= 2'd0;
        end else if (reading) begin
            rd_pix_cnt <= rd_pix_cnt + 1'b1;
            if (rd_last) begin
                rd_line_sel <= rd_line_sel + 2'd1;
            end
        end
    end

    // Occupancy: +1 per accepted write, -1 per read cycle, hold when both.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt <= '0;
        end else begin
            case ({wr_accept, reading})
                2'b10:   fill_cnt <= fill_cnt + 1'b1;
                2'b01:   fill_cnt <= fill_cnt - 1'b1;
                default: fill_cnt <= fill_cnt;
            endcase
        end
    end

    // Buffer-released flag: set after the last read of a line, cleared when
    // the next burst starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_buff_empty <= 1'b0;
        end else if (rd_last) begin
            rd_buff_empty <= 1'b1;
        end else if (read_start) begin
            rd_buff_empty <= 1'b0;
        end
    end

    assign bus.rdBuffEmpty = rd_buff_empty;

`ifdef LB_CTRL_OVF_DET_EN
    logic ovf_err;

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err <= 1'b0;
        end else if (wr_drop) begin
            ovf_err <= 1'b1;
        end
    end

    assign bus.ovfErr = ovf_err;
`else
    assign bus.ovfErr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_buffer_ctrl
//  Description : Self-checking bench for line_buffer_ctrl (IMG_WIDTH=8,
//                DATA_WIDTH=8): table-driven fill/first-read vectors plus
//                ring-wrap, simultaneous read/write, overflow and mid-burst
//                reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_line_buffer_ctrl;

    localparam int DW = 8;
    localparam int IW = 8;

`ifdef LB_CTRL_OVF_DET_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    line_buffer_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    line_buffer_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       valid;
        logic [3:0] wr;
        logic [3:0] rd;
        logic       wv;
        logic       empty;
        int         fill;
    } vec_t;

    vec_t tbl [35];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [71:0] exp_window(input logic [95:0] d, input int sel);
        logic [23:0] r [3];
        for (int k = 0; k < 3; k++) begin
            r[k] = d[((sel + k) % 4)*24 +: 24];
        end
        return {r[2], r[1], r[0]};
    endfunction

    // Advance to the next cycle, drive inputs at the falling edge, settle.
    task automatic tick(input logic v);
        @(negedge clk);
        bus.inPixelValid = v;
        bus.lbRdData     = {$urandom(), $urandom(), $urandom()};
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.inPixelValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_wrEn",  bus.lbWrEn,      4'b0000);
        check("rst_rdEn",  bus.lbRdEn,      4'b0000);
        check("rst_wv",    bus.windowValid, 1'b0);
        check("rst_empty", bus.rdBuffEmpty, 1'b0);
        check("rst_ovf",   bus.ovfErr,      1'b0);
        check("rst_fill",  dut.fill_cnt,    0);
        rst = 1'b0;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 35; i++) begin
            tick(tbl[i].valid);
            check({tag, "_wrEn"},  bus.lbWrEn,      tbl[i].wr);
            check({tag, "_rdEn"},  bus.lbRdEn,      tbl[i].rd);
            check({tag, "_wv"},    bus.windowValid, tbl[i].wv);
            check({tag, "_empty"}, bus.rdBuffEmpty, tbl[i].empty);
            check({tag, "_fill"},  dut.fill_cnt,    tbl[i].fill);
            if (tbl[i].wv) begin
                check({tag, "_window"}, bus.window, exp_window(bus.lbRdData, 0));
            end
        end
    endtask

    initial begin
        logic [3:0] rd_pat [4];
        int pending, lines_sent, words, burst_idx, blen;
        logic prev_wv, prev_empty;

        rd_pat[0] = 4'b0111;
        rd_pat[1] = 4'b1110;
        rd_pat[2] = 4'b1101;
        rd_pat[3] = 4'b1011;

        rst = 1'b1;
        bus.inPixelValid = 1'b0;
        bus.lbRdData     = '0;

        // Fill and first read: 24 writes, one IDLE cycle at the threshold,
        // an 8-cycle burst from buffers 0..2, then the released flag.
        for (int i = 0; i < 35; i++) begin
            tbl[i].valid = (i < 24);
            tbl[i].wr    = (i < 24) ? (4'b0001 << (i / 8)) : 4'b0000;
            tbl[i].rd    = (i >= 25 && i <= 32) ? 4'b0111 : 4'b0000;
            tbl[i].wv    = (i >= 25 && i <= 32);
            tbl[i].empty = (i >= 33);
            tbl[i].fill  = (i <= 24) ? i : (i <= 32) ? (24 - (i - 25)) : 16;
        end

        do_reset();
        run_table("fill");

        // Ring wrap with writes overlapping bursts: 4 lines, then one line
        // per rising edge of rdBuffEmpty, 8 lines total -> 6 bursts.
        do_reset();
        pending = 32; lines_sent = 4; words = 0; burst_idx = 0; blen = 0;
        prev_wv = 1'b0; prev_empty = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            logic v;
            v = (pending > 0);
            tick(v);
            if (v) begin
                pending--;
                check("ring_wrEn", bus.lbWrEn, 4'b0001 << ((words / 8) % 4));
                words++;
            end
            if (cyc >= 25 && cyc <= 32) begin
                check("simul_fill", dut.fill_cnt, 25);
            end
            if (bus.windowValid) begin
                check("ring_rdEn", bus.lbRdEn, rd_pat[burst_idx % 4]);
                check("ring_window", bus.window, exp_window(bus.lbRdData, burst_idx % 4));
                blen++;
            end
            if (!bus.windowValid && prev_wv) begin
                check("burst_len", blen, 8);
                burst_idx++;
                blen = 0;
            end
            if (bus.rdBuffEmpty && !prev_empty && lines_sent < 8) begin
                pending += 8;
                lines_sent++;
            end
            prev_wv    = bus.windowValid;
            prev_empty = bus.rdBuffEmpty;
        end
        check("ring_bursts", burst_idx, 6);
        check("ring_lines",  lines_sent, 8);
        check("ring_fill",   dut.fill_cnt, 16);

        // Overflow: a continuous stream gains one slot per IDLE cycle and
        // hits 32 at cycle 96, where the write is dropped.
        do_reset();
        for (int cyc = 0; cyc < 100; cyc++) begin
            tick(1'b1);
            if (cyc == 95) begin
                check("ovf_pre_wrEn", bus.lbWrEn,   4'b1000);
                check("ovf_pre_fill", dut.fill_cnt, 32);
            end
            if (cyc == 96) begin
                check("ovf_drop_wrEn", bus.lbWrEn,      4'b0000);
                check("ovf_drop_fill", dut.fill_cnt,    32);
                check("ovf_drop_wv",   bus.windowValid, 1'b0);
                check("ovf_drop_flag", bus.ovfErr,      1'b0);
            end
            if (cyc == 97) begin
                check("ovf_post_fill", dut.fill_cnt, 32);
                check("ovf_post_wrEn", bus.lbWrEn,   4'b0001);
                check("ovf_flag",      bus.ovfErr,   EXP_OVF);
            end
        end
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick(1'b0);
        end
        check("ovf_sticky", bus.ovfErr, EXP_OVF);

        // Reset on the 4th windowValid cycle, then a fresh fill.
        do_reset();
        for (int cyc = 0; cyc < 29; cyc++) begin
            tick(cyc < 24);
        end
        check("mid_wv_before", bus.windowValid, 1'b1);
        rst = 1'b1;
        tick(1'b0);
        check("mid_wv",    bus.windowValid, 1'b0);
        check("mid_rdEn",  bus.lbRdEn,      4'b0000);
        check("mid_empty", bus.rdBuffEmpty, 1'b0);
        check("mid_fill",  dut.fill_cnt,    0);
        rst = 1'b0;
        run_table("refill");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
